// File: rtl/ram_dp_be.sv
// Simple dual-port (1W/1R) RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a word-per-cycle clear sequencer.
module ram_dp_be #(
    parameter int unsigned          DATA_W   = 64,
    parameter int unsigned          DEPTH    = 128,
    parameter int unsigned          ADDR_W   = $clog2(DEPTH),
    parameter int unsigned          RD_LAT   = 1,
    parameter int unsigned          RDW_MODE = 0,
    parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic                  drop
);

    localparam int unsigned       NumBytes = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_in_range, rd_in_range;
    logic                wr_ok, rd_ok;
    logic [DATA_W-1:0]   wr_old, wr_merged, rd_old, rd_word;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic                s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]   s1_data_q, s1_data_d;
    logic                drop_q, drop_d;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d   = StClear;
                    clr_ptr_d = '0;
                end
            end
            StClear: begin
                if (clr_ptr_q == LastAddr) begin
                    state_d   = StIdle;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        busy = (state_q == StClear);
    end

    // ---------------------------------------------------------- datapath
    always_comb begin
        wr_in_range = (32'(wr_addr) < DEPTH);
        rd_in_range = (32'(rd_addr) < DEPTH);
        wr_ok       = !busy && wr_en && wr_in_range;
        rd_ok       = !busy && rd_en;

        wr_old = wr_in_range ? mem_q[wr_addr] : '0;
        rd_old = rd_in_range ? mem_q[rd_addr] : '0;

        wr_merged = wr_old;
        for (int i = 0; i < NumBytes; i++) begin
            if (wr_be[i]) begin
                wr_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end

        // Write-first bypass: a same-cycle write to the read address is forwarded.
        rd_word = '0;
        if (rd_in_range) begin
            if (RDW_MODE == 0 && wr_ok && wr_addr == rd_addr) begin
                rd_word = wr_merged;
            end else begin
                rd_word = rd_old;
            end
        end

        // Memory is left untouched while reset is held.
        mem_we    = rst_n && (busy || wr_ok);
        mem_waddr = busy ? clr_ptr_q : wr_addr;
        mem_wdata = busy ? INIT_VAL : wr_merged;

        drop_d = busy ? (wr_en || rd_en)
                      : ((wr_en && !wr_in_range) || (rd_en && !rd_in_range));

        s1_valid_d = rd_ok;
        s1_data_d  = rd_ok ? rd_word : s1_data_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            drop_q     <= drop_d;
        end
    end

    assign drop = drop_q;

    // ------------------------------------------------- optional 2nd stage
    if (RD_LAT == 2) begin : g_lat2
        logic                s2_valid_q, s2_valid_d;
        logic [DATA_W-1:0]   s2_data_q, s2_data_d;

        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign rd_valid = s2_valid_q;
        assign rd_data  = s2_data_q;
    end else begin : g_lat1
        assign rd_valid = s1_valid_q;
        assign rd_data  = s1_data_q;
    end

endmodule
